// File: rtl/iob_eth_rx_frame_gen.sv
// MII receive-side frame source: preamble, SFD, buffered payload, optional FCS, then IFG.
// Define IOB_ETH_RX_GEN_FCS_EN to append a computed FCS; otherwise the buffer carries it.
module iob_eth_rx_frame_gen #(
    parameter int BUF_ADDR_W     = 11,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_NIBBLES    = 24
) (
    input  logic                  rx_clk_i,
    input  logic                  arst_i,
    input  logic                  send_i,
    input  logic [BUF_ADDR_W-1:0] len_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_o,
    output logic [BUF_ADDR_W-1:0] addr_o,
    input  logic [7:0]            data_i,
    output logic                  rx_dv_o,
    output logic [3:0]            rx_data_o
);
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, FCS, IFG} state_t;

    state_t                state_q;
    logic [15:0]           cnt_q;
    logic [BUF_ADDR_W-1:0] len_q;
    logic [BUF_ADDR_W-1:0] byte_idx_q;
    logic [3:0]            hi_q;
    logic                  show_hi_q;
    logic                  last_byte;
    logic                  more_rd;
    logic                  in_frame;
    logic                  payload_done;
    logic                  frame_end;
    logic [BUF_ADDR_W:0]   idx_plus2;

`ifdef IOB_ETH_RX_GEN_FCS_EN
    localparam logic FCS_ON = 1'b1;
    logic [31:0] crc_q;
    logic [31:0] fcs_w;
    logic [2:0]  fcs_idx_nxt;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ (32'hEDB88320 & {32{r[0] ^ d[i]}});
        return r;
    endfunction

    assign fcs_w       = ~crc_q;
    assign fcs_idx_nxt = cnt_q[2:0] + 3'd1;
`else
    localparam logic FCS_ON = 1'b0;
`endif

    // The byte after next is requested while the current byte is on the wire,
    // so data_i lands exactly on the edge that shows its low nibble.
    assign last_byte    = (byte_idx_q == len_q - BUF_ADDR_W'(1));
    assign idx_plus2    = {1'b0, byte_idx_q} + (BUF_ADDR_W+1)'(2);
    assign more_rd      = (idx_plus2 < {1'b0, len_q});
    assign in_frame     = (state_q == PRE) || (state_q == SFD) || (state_q == DATA) || (state_q == FCS);
    assign payload_done = ((state_q == SFD) && (cnt_q == '0) && (len_q == '0)) ||
                          ((state_q == DATA) && !show_hi_q && last_byte);
    assign frame_end    = (in_frame && abort_i) ||
                          ((state_q == FCS) && (cnt_q == 16'd7)) ||
                          (!FCS_ON && payload_done);

    always_ff @(posedge rx_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            hi_q       <= '0;
            show_hi_q  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rd_o       <= 1'b0;
            addr_o     <= '0;
            rx_dv_o    <= 1'b0;
            rx_data_o  <= '0;
`ifdef IOB_ETH_RX_GEN_FCS_EN
            crc_q      <= '1;
`endif
        end else begin
            rd_o   <= 1'b0;
            done_o <= 1'b0;
            case (state_q)
                IDLE: if (send_i) begin
                    state_q   <= PRE;
                    len_q     <= len_i;
                    cnt_q     <= 16'(2*PREAMBLE_BYTES-1);
                    busy_o    <= 1'b1;
                    rx_dv_o   <= 1'b1;
                    rx_data_o <= 4'h5;
`ifdef IOB_ETH_RX_GEN_FCS_EN
                    crc_q     <= '1;
`endif
                end
                PRE: if (cnt_q == '0) begin
                    state_q <= SFD;
                    cnt_q   <= 16'd1;
                    rd_o    <= (len_q != '0);
                    addr_o  <= '0;
                end else begin
                    cnt_q <= cnt_q - 16'd1;
                end
                SFD: if (cnt_q != '0) begin
                    cnt_q     <= '0;
                    rx_data_o <= 4'hD;
                end else if (len_q != '0) begin
                    state_q    <= DATA;
                    rx_data_o  <= data_i[3:0];
                    hi_q       <= data_i[7:4];
                    byte_idx_q <= '0;
                    show_hi_q  <= 1'b1;
                    rd_o       <= (len_q > BUF_ADDR_W'(1));
                    addr_o     <= BUF_ADDR_W'(1);
`ifdef IOB_ETH_RX_GEN_FCS_EN
                    crc_q      <= crc_byte(crc_q, data_i);
`endif
                end else begin
`ifdef IOB_ETH_RX_GEN_FCS_EN
                    state_q   <= FCS;
                    cnt_q     <= '0;
                    rx_data_o <= fcs_w[3:0];
`endif
                end
                DATA: if (show_hi_q) begin
                    rx_data_o <= hi_q;
                    show_hi_q <= 1'b0;
                end else if (!last_byte) begin
                    rx_data_o  <= data_i[3:0];
                    hi_q       <= data_i[7:4];
                    byte_idx_q <= byte_idx_q + BUF_ADDR_W'(1);
                    show_hi_q  <= 1'b1;
                    rd_o       <= more_rd;
                    addr_o     <= idx_plus2[BUF_ADDR_W-1:0];
`ifdef IOB_ETH_RX_GEN_FCS_EN
                    crc_q      <= crc_byte(crc_q, data_i);
`endif
                end else begin
`ifdef IOB_ETH_RX_GEN_FCS_EN
                    state_q   <= FCS;
                    cnt_q     <= '0;
                    rx_data_o <= fcs_w[3:0];
`endif
                end
`ifdef IOB_ETH_RX_GEN_FCS_EN
                FCS: begin
                    cnt_q     <= cnt_q + 16'd1;
                    rx_data_o <= fcs_w[{fcs_idx_nxt, 2'b00} +: 4];
                end
`endif
                IFG: if (cnt_q == '0) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Normal completion and abort share one IFG entry; it overrides the case above.
            if (frame_end) begin
                state_q   <= IFG;
                rx_dv_o   <= 1'b0;
                rx_data_o <= '0;
                rd_o      <= 1'b0;
                cnt_q     <= 16'(IFG_NIBBLES-1);
                done_o    <= (IFG_NIBBLES == 1);
                busy_o    <= (IFG_NIBBLES != 1);
            end
        end
    end
endmodule

// File: doc/iob_eth_rx_frame_gen.md
Name: iob_eth_rx_frame_gen

Overview:
MII frame source that drives the receive-side MII pins (rx_dv/rx_data) of iob_eth_rx from a byte buffer, clocked by rx_clk_i. Used for internal loopback and self-test of the RX path without an external PHY. Emits preamble, SFD, payload nibbles (low nibble first), optional IEEE 802.3 FCS, then an inter-frame gap.

Parameters:
BUF_ADDR_W, 11, buffer address width and len_i width
PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD (1..15)
IFG_NIBBLES, 24, idle cycles with rx_dv_o low after the frame (>=1)

Ports:
rx_clk_i  in  1  MII receive clock; all logic on rising edge
arst_i  in  1  asynchronous reset, active-high
send_i  in  1  start request, sampled only in IDLE
len_i  in  BUF_ADDR_W  payload byte count, latched with send_i
abort_i  in  1  terminate current frame
busy_o  out  1  high from accepted send_i until done_o
done_o  out  1  one-cycle pulse at end of IFG
rd_o  out  1  buffer read strobe
addr_o  out  BUF_ADDR_W  buffer read address
data_i  in  8  buffer read data, valid the cycle after rd_o
rx_dv_o  out  1  MII data valid toward receiver
rx_data_o  out  4  MII nibble toward receiver

Behaviour:
- Reset (async): state IDLE; rx_dv_o=0, rx_data_o=0, busy_o=0, done_o=0, rd_o=0, addr_o=0, CRC=0xFFFFFFFF.
- States: IDLE -> PRE -> SFD -> DATA -> FCS -> IFG -> IDLE.
- IDLE: send_i=1 latches len_i, sets busy_o next cycle, enters PRE; rx_dv_o rises the cycle after send_i is sampled.
- PRE: 2*PREAMBLE_BYTES cycles, rx_data_o=0x5. SFD: 2 cycles, nibbles 0x5 then 0xD.
- DATA: 2*len cycles; byte k sent low nibble then high nibble. len=0 skips DATA.
- Buffer reads: addr_o sequence 0..len-1, each address read exactly once with a one-cycle rd_o. No read at or beyond len. Byte 0 is prefetched during PRE/SFD. Byte k+1 is fetched while byte k is on the wire, so there are no gaps in rx_dv_o.
- CRC: reflected poly 0xEDB88320, init 0xFFFFFFFF, updated on each payload byte, reinitialised on entry to PRE. FCS = ~CRC, sent LSB byte first, low nibble first (8 cycles).
- IFG: rx_dv_o=0, rx_data_o=0 for IFG_NIBBLES cycles. On the last IFG cycle, done_o pulses for 1 cycle. busy_o drops in the same cycle. IDLE is entered next cycle.
- Total rx_dv_o high cycles: 2*PREAMBLE_BYTES + 2 + 2*len + (8 if FCS appended). rx_dv_o never drops inside a frame except on abort.
- send_i while busy_o=1: ignored, no queuing. send_i and done_o in the same cycle: send_i ignored.
- abort_i in PRE/SFD/DATA/FCS: rx_dv_o=0 and rd_o=0 from the next cycle, then a full IFG, then done_o. abort_i in IDLE/IFG: no effect.
- Reset mid-frame: rx_dv_o low immediately (async) and IDLE. No done_o is produced for the interrupted frame.
- len_i=2^BUF_ADDR_W-1 is legal; the address counter must not wrap before the last byte.

Optional Feature:
Macro IOB_ETH_RX_GEN_FCS_EN.
- Defined: CRC logic present; FCS state appends 4 computed bytes after the payload.
- Undefined: no CRC logic; FCS state skipped, DATA goes directly to IFG. The buffer is expected to hold the FCS as its last 4 bytes, and it is sent verbatim.

Test Plan:
1. FCS_EN, send len=9, buffer "123456789" -> rx_dv_o high 42 cycles. Nibbles after SFD: 1,3,2,3,... then FCS nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926). done_o 24 cycles after rx_dv_o falls.
2. FCS_EN, len=0 -> preamble, SFD, FCS nibbles all 0x0; rx_dv_o high 24 cycles; rd_o never asserted.
3. Loopback into iob_eth_rx, 64-byte frame with correct dest MAC -> receiver writes 64 payload bytes plus 4 FCS bytes matching source, crc_err_o=0, data_rcvd_o=1.
4. send_i pulsed again during DATA, then abort_i at DATA byte 3 -> second send ignored; rx_dv_o low the next cycle; last addr_o read <=4; IFG 24 cycles; one done_o.
5. arst_i asserted mid-DATA -> rx_dv_o, busy_o, rd_o low asynchronously; no done_o. A subsequent send of len=2 produces a clean frame.
6. FCS_EN undefined, len=13 -> rx_dv_o high 42 cycles; all 13 buffer bytes sent verbatim; no extra nibbles.
